i4002_bank: RTL and testbench

//  Parametrised successor to the single 4002 RAM model: one instance models a whole RAM bank
//  of 1-4 chips sharing one CM-RAM line. Regenerates the 8-phase instruction cycle from sync,

---
 rtl/mcs4_pkg.sv | 22 ++
 rtl/mcs4_phase_gen.sv | 33 +++
 rtl/i4002_bank.sv | 143 ++++++++++++++
 tb/tb_i4002_bank.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types: data character, 8-phase instruction cycle, I/O-RAM OPA codes,
// and the maximum RAM geometry of a single 4002 chip.
package mcs4;

    typedef logic [3:0] char_t;

    typedef enum logic [2:0] {
        PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
    } instr_cyc_t;

    typedef enum logic [3:0] {
        WRM = 4'h0, WMP = 4'h1, WRR = 4'h2, WPM = 4'h3,
        WR0 = 4'h4, WR1 = 4'h5, WR2 = 4'h6, WR3 = 4'h7,
        SBM = 4'h8, RDM = 4'h9, RDR = 4'hA, ADM = 4'hB,
        RD0 = 4'hC, RD1 = 4'hD, RD2 = 4'hE, RD3 = 4'hF
    } ioram_opa_t;

    localparam int Ram_regs_per_chip  = 4;
    localparam int Ram_chars_per_reg  = 16;
    localparam int Ram_status_per_reg = 4;

endpackage

// File: rtl/mcs4_phase_gen.sv
// Regenerates the 8-phase instruction cycle from the sync marker; shared by ROM/RAM models.
//  state | meaning
//  A1-A3 | address nibbles on the bus
//  M1-M2 | opcode nibbles (OPR, OPA)
//  X1-X3 | execute; X2/X3 carry data or SRC address
module mcs4_phase_gen
    import mcs4::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    output instr_cyc_t phase
);

    instr_cyc_t phase_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH_A1;
        end else begin
            phase <= phase_next;
        end
    end

    // X3 wraps to A1 naturally; sync realigns from any phase.
    always_comb begin
        phase_next = instr_cyc_t'(phase + 3'd1);
        if (sync) begin
            phase_next = PH_A1;
        end
    end

endmodule

// File: rtl/i4002_bank.sv
// Bank of 1-4 i4002 RAM chips sharing one CM-RAM line: SRC addressing, RAM/port/status I/O.
// Status characters exist only when I4002_BANK_STATUS_EN is defined.
module i4002_bank
    import mcs4::*;
#(
    parameter int NUM_CHIPS  = 4,
    parameter int CHIP_BASE  = 0,
    parameter int NUM_REGS   = 4,
    parameter int NUM_CHARS  = 16,
    parameter int NUM_STATUS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clken_1,
    input  logic                   clken_2,
    input  logic                   sync,
    input  logic                   cm_ram,
    input  logic [3:0]             dbus_in,
    output logic [3:0]             dbus_out,
    output logic                   dbus_oe,
    output logic [NUM_CHIPS*4-1:0] io_out
);

    localparam logic [2:0] CHIP_LO  = 3'(CHIP_BASE);
    localparam logic [2:0] CHIP_HI  = 3'(CHIP_BASE + NUM_CHIPS - 1);
    localparam logic [1:0] CHIP_OFS = 2'(CHIP_BASE);
    localparam logic [2:0] REG_LIM  = 3'(NUM_REGS);
    localparam logic [4:0] CHAR_LIM = 5'(NUM_CHARS);

    instr_cyc_t phase;
    ioram_opa_t opa;
    logic       opa_pend;
    logic       src_pend;
    logic [1:0] chip_q;
    logic [1:0] reg_q;
    char_t      char_q;
    logic [1:0] chip_rel;
    logic       selected;
    logic       addr_ok;
    logic       exec;
    logic       unused_clken;

    char_t mem [4][Ram_regs_per_chip][Ram_chars_per_reg];

    assign unused_clken = clken_1 ^ clken_2;

    mcs4_phase_gen u_phase (
        .clk   (clk),
        .rst   (rst),
        .sync  (sync),
        .phase (phase)
    );

    assign chip_rel = chip_q - CHIP_OFS;
    assign selected = ({1'b0, chip_q} >= CHIP_LO) && ({1'b0, chip_q} <= CHIP_HI);
    assign addr_ok  = ({1'b0, reg_q} < REG_LIM) && ({1'b0, char_q} < CHAR_LIM);
    assign exec     = !rst && (phase == PH_X2) && opa_pend && selected;

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_pend <= 1'b0;
            opa      <= WRM;
            src_pend <= 1'b0;
            chip_q   <= 2'd0;
            reg_q    <= 2'd0;
            char_q   <= 4'd0;
            io_out   <= '0;
        end else begin
            if (phase == PH_M2) begin
                opa_pend <= cm_ram;
                opa      <= ioram_opa_t'(dbus_in);
            end else if (phase == PH_X3) begin
                opa_pend <= 1'b0;
            end
            // SRC: CM-RAM at X2 without a pending I/O opcode.
            if ((phase == PH_X2) && cm_ram && !opa_pend) begin
                chip_q   <= dbus_in[3:2];
                reg_q    <= dbus_in[1:0];
                src_pend <= 1'b1;
            end else if ((phase == PH_X3) && src_pend) begin
                char_q   <= dbus_in;
                src_pend <= 1'b0;
            end
            if (exec && (opa == WMP)) begin
                for (int k = 0; k < NUM_CHIPS; k++) begin
                    if (chip_rel == 2'(k)) begin
                        io_out[k*4 +: 4] <= dbus_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (exec && addr_ok && (opa == WRM)) begin
            mem[chip_rel][reg_q][char_q] <= dbus_in;
        end
    end

`ifdef I4002_BANK_STATUS_EN
    localparam logic [2:0] STAT_LIM = 3'(NUM_STATUS);

    char_t      status [4][Ram_regs_per_chip][Ram_status_per_reg];
    logic [1:0] stat_n;
    logic       stat_ok;

    assign stat_n  = opa[1:0];
    assign stat_ok = ({1'b0, reg_q} < REG_LIM) && ({1'b0, stat_n} < STAT_LIM);

    always_ff @(posedge clk) begin
        if (exec && stat_ok && (opa inside {WR0, WR1, WR2, WR3})) begin
            status[chip_rel][reg_q][stat_n] <= dbus_in;
        end
    end
`endif

    // Zero-latency read: data is on the bus during the same X2 clock.
    always_comb begin
        dbus_out = 4'h0;
        dbus_oe  = 1'b0;
        if (exec) begin
            case (opa)
                SBM, RDM, ADM: begin
                    dbus_oe = 1'b1;
                    if (addr_ok) begin
                        dbus_out = mem[chip_rel][reg_q][char_q];
                    end
                end
                RD0, RD1, RD2, RD3: begin
                    dbus_oe = 1'b1;
`ifdef I4002_BANK_STATUS_EN
                    if (stat_ok) begin
                        dbus_out = status[chip_rel][reg_q][stat_n];
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i4002_bank.sv
// Scoreboard bench for i4002_bank: two banks (2 chips x 16 chars, 4 chips x 8 chars) on one bus.
module tb_i4002_bank;

    localparam logic [3:0] OP_WRM = 4'h0;
    localparam logic [3:0] OP_WMP = 4'h1;
    localparam logic [3:0] OP_WRR = 4'h2;
    localparam logic [3:0] OP_WR2 = 4'h6;
    localparam logic [3:0] OP_SBM = 4'h8;
    localparam logic [3:0] OP_RDM = 4'h9;
    localparam logic [3:0] OP_RDR = 4'hA;
    localparam logic [3:0] OP_ADM = 4'hB;
    localparam logic [3:0] OP_RD2 = 4'hE;

    typedef struct {
        string      name;
        logic       chk_a;
        logic       oe_a;
        logic [3:0] d_a;
        logic       chk_b;
        logic       oe_b;
        logic [3:0] d_b;
    } x2_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clken_1;
    logic        clken_2;
    logic        sync;
    logic        cm_ram;
    logic [3:0]  dbus_in;
    logic [3:0]  a_dout;
    logic        a_oe;
    logic [7:0]  a_io;
    logic [3:0]  b_dout;
    logic        b_oe;
    logic [15:0] b_io;

    int      checks = 0;
    int      errors = 0;
    x2_exp_t sb[$];

    always #5 clk = ~clk;

    i4002_bank #(.NUM_CHIPS(2), .CHIP_BASE(0), .NUM_REGS(4), .NUM_CHARS(16), .NUM_STATUS(4)) u_a (
        .clk(clk), .rst(rst), .clken_1(clken_1), .clken_2(clken_2), .sync(sync),
        .cm_ram(cm_ram), .dbus_in(dbus_in), .dbus_out(a_dout), .dbus_oe(a_oe), .io_out(a_io)
    );

    i4002_bank #(.NUM_CHIPS(4), .CHIP_BASE(0), .NUM_REGS(4), .NUM_CHARS(8), .NUM_STATUS(2)) u_b (
        .clk(clk), .rst(rst), .clken_1(clken_1), .clken_2(clken_2), .sync(sync),
        .cm_ram(cm_ram), .dbus_in(dbus_in), .dbus_out(b_dout), .dbus_oe(b_oe), .io_out(b_io)
    );

    task automatic push_exp(input string name, input logic chk_a, input logic oe_a,
                            input logic [3:0] d_a, input logic chk_b, input logic oe_b,
                            input logic [3:0] d_b);
        x2_exp_t e;
        e.name  = name;
        e.chk_a = chk_a;
        e.oe_a  = oe_a;
        e.d_a   = d_a;
        e.chk_b = chk_b;
        e.oe_b  = oe_b;
        e.d_b   = d_b;
        sb.push_back(e);
    endtask

    // One full A1..X3 cycle; sync in X3 keeps the banks aligned. X2 output is scored here.
    task automatic instr_cycle(input logic m2_cm, input logic [3:0] m2_d, input logic x2_cm,
                               input logic [3:0] x2_d, input logic [3:0] x3_d);
        x2_exp_t e;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            sync    = (p == 7);
            cm_ram  = (p == 4) ? m2_cm : ((p == 6) ? x2_cm : 1'b0);
            dbus_in = (p == 4) ? m2_d : (p == 6) ? x2_d : (p == 7) ? x3_d : 4'h0;
            #1;
            if (p == 6) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                end else begin
                    e.name = "idle_x2";
                    e.chk_a = 1'b1; e.oe_a = 1'b0; e.d_a = 4'h0;
                    e.chk_b = 1'b1; e.oe_b = 1'b0; e.d_b = 4'h0;
                end
                if (e.chk_a) begin
                    checks++;
                    if (a_oe !== e.oe_a || a_dout !== e.d_a) begin
                        errors++;
                        $display("FAIL %s bank_a: got oe=%b data=%h, expected oe=%b data=%h",
                                 e.name, a_oe, a_dout, e.oe_a, e.d_a);
                    end
                end
                if (e.chk_b) begin
                    checks++;
                    if (b_oe !== e.oe_b || b_dout !== e.d_b) begin
                        errors++;
                        $display("FAIL %s bank_b: got oe=%b data=%h, expected oe=%b data=%h",
                                 e.name, b_oe, b_dout, e.oe_b, e.d_b);
                    end
                end
            end else begin
                checks++;
                if (a_oe !== 1'b0 || b_oe !== 1'b0 || a_dout !== 4'h0 || b_dout !== 4'h0) begin
                    errors++;
                    $display("FAIL bus_quiet phase %0d: got a_oe=%b a_d=%h b_oe=%b b_d=%h, expected all 0",
                             p, a_oe, a_dout, b_oe, b_dout);
                end
            end
        end
    endtask

    task automatic src(input logic [3:0] chip_reg, input logic [3:0] chr);
        instr_cycle(1'b0, 4'h0, 1'b1, chip_reg, chr);
    endtask

    task automatic io_op(input logic [3:0] opa, input logic [3:0] acc);
        instr_cycle(1'b1, opa, 1'b0, acc, 4'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; sync = 1'b0; cm_ram = 1'b0; dbus_in = 4'h0;
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        sync = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sync = 1'b0; cm_ram = 1'b0; dbus_in = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_io !== 8'h00 || b_io !== 16'h0000) begin
            errors++;
            $display("FAIL reset_io: got a=%h b=%h, expected 0", a_io, b_io);
        end
        checks++;
        if (a_oe !== 1'b0 || a_dout !== 4'h0 || b_oe !== 1'b0 || b_dout !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus: got a_oe=%b a_d=%h b_oe=%b b_d=%h, expected 0",
                     a_oe, a_dout, b_oe, b_dout);
        end
        rst  = 1'b0;
        sync = 1'b1;
    endtask

    task automatic test_wrm_rdm();
        src(4'h6, 4'h9);
        io_op(OP_WRM, 4'hA);
        src(4'h6, 4'h9);
        push_exp("rdm_chip1_r2_c9", 1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 4'h0);
        io_op(OP_RDM, 4'h0);
    endtask

    task automatic test_unselected_chip();
        src(4'h0, 4'h0); io_op(OP_WRM, 4'h3);
        src(4'h4, 4'h0); io_op(OP_WRM, 4'h4);
        src(4'hC, 4'h0); io_op(OP_WRM, 4'hF);
        push_exp("rdm_chip3", 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hF);
        io_op(OP_RDM, 4'h0);
        src(4'h0, 4'h0);
        push_exp("rdm_chip0_kept", 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'h3);
        io_op(OP_RDM, 4'h0);
        src(4'h4, 4'h0);
        push_exp("rdm_chip1_kept", 1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4);
        io_op(OP_RDM, 4'h0);
    endtask

    task automatic test_wmp();
        src(4'h4, 4'h0);
        io_op(OP_WMP, 4'h5);
        checks++;
        if (a_io !== 8'h50) begin
            errors++;
            $display("FAIL wmp_a: got io=%h, expected 50", a_io);
        end
        checks++;
        if (b_io !== 16'h0050) begin
            errors++;
            $display("FAIL wmp_b: got io=%h, expected 0050", b_io);
        end
        apply_reset();
        #1;
        checks++;
        if (a_io !== 8'h00 || b_io !== 16'h0000) begin
            errors++;
            $display("FAIL wmp_reset: got a=%h b=%h, expected 0", a_io, b_io);
        end
    endtask

    task automatic test_status();
        logic [3:0] exp_a;
`ifdef I4002_BANK_STATUS_EN
        exp_a = 4'hC;
`else
        exp_a = 4'h0;
`endif
        src(4'h1, 4'h0);
        io_op(OP_WR2, 4'hC);
        push_exp("rd2_reg1", 1'b1, 1'b1, exp_a, 1'b1, 1'b1, 4'h0);
        io_op(OP_RD2, 4'h0);
    endtask

    task automatic test_char_limit();
        src(4'h0, 4'h3); io_op(OP_WRM, 4'h2);
        src(4'h0, 4'hB); io_op(OP_WRM, 4'h7);
        push_exp("rdm_char_b", 1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 4'h0);
        io_op(OP_RDM, 4'h0);
        src(4'h0, 4'h3);
        push_exp("rdm_char_3", 1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 4'h2);
        io_op(OP_RDM, 4'h0);
    endtask

    task automatic test_reset_abort_and_sync();
        src(4'h0, 4'h0); io_op(OP_WRM, 4'h3);
        src(4'h0, 4'h3);
        // WRM with reset landing in X1, before its X2 write.
        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            sync    = 1'b0;
            cm_ram  = (p == 4);
            dbus_in = (p == 4) ? OP_WRM : 4'hE;
            rst     = (p == 5);
        end
        @(negedge clk);
        cm_ram = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        sync = 1'b1;
        instr_cycle(1'b0, 4'h0, 1'b0, 4'hE, 4'h0);
        push_exp("rdm_after_reset", 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'h3);
        io_op(OP_RDM, 4'h0);
        // Early sync in A3 must restart the cycle at A1.
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            sync    = (p == 2);
            cm_ram  = 1'b0;
            dbus_in = 4'h0;
        end
        push_exp("rdm_after_sync", 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'h3);
        io_op(OP_RDM, 4'h0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] model [4];
        logic [3:0] rd_op;
        for (int i = 0; i < 4; i++) begin
            model[i] = 4'($urandom_range(0, 15));
            src(4'h2, 4'(i));
            io_op(OP_WRM, model[i]);
        end
        io_op(OP_WRR, 4'h9);
        io_op(OP_RDR, 4'h0);
        for (int i = 0; i < 4; i++) begin
            rd_op = (i == 1) ? OP_SBM : (i == 2) ? OP_ADM : OP_RDM;
            src(4'h2, 4'(i));
            push_exp("b2b_read", 1'b1, 1'b1, model[i], 1'b1, 1'b1, model[i]);
            io_op(rd_op, 4'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        clken_1 = 1'b1;
        clken_2 = 1'b1;
        test_reset();
        test_wrm_rdm();
        test_unselected_chip();
        test_wmp();
        test_status();
        test_char_limit();
        test_reset_abort_and_sync();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
